// File: rtl/branch_pred_unit.sv
// Branch predictor: saturating-counter PHT (bimodal or gshare), tagged direct-mapped BTB,
// speculative global history with mispredict repair, and a post-reset table-clearing sweep.
module branch_pred_unit #(
    parameter int PHT_ENTRIES = 256,
    parameter int BTB_ENTRIES = 64,
    parameter int GHR_BITS    = 8,
    parameter int CTR_BITS    = 2,
    parameter int MODE        = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         if_pc,
    input  logic                if_is_branch,
    input  logic                stall,
    output logic                pred_taken,
    output logic                btb_hit,
    output logic [31:0]         pred_target,
    output logic [GHR_BITS-1:0] pred_ghr,
    input  logic                upd_valid,
    input  logic [31:0]         upd_pc,
    input  logic                upd_taken,
    input  logic [31:0]         upd_target,
    input  logic [GHR_BITS-1:0] upd_ghr,
    input  logic                upd_mispredict,
    output logic                init_done,
    output logic [31:0]         stat_branches,
    output logic [31:0]         stat_mispredicts
);
    localparam int IW    = $clog2(PHT_ENTRIES);
    localparam int BW    = $clog2(BTB_ENTRIES);
    localparam int TW    = 30 - BW;
    localparam int SWEEP = (PHT_ENTRIES > BTB_ENTRIES) ? PHT_ENTRIES : BTB_ENTRIES;
    localparam int SCW   = $clog2(SWEEP) + 1;

    localparam logic [CTR_BITS-1:0] CTR_WNT = {1'b0, {(CTR_BITS-1){1'b1}}};
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t             state;
    logic [SCW-1:0]     sweep_cnt;
    logic [GHR_BITS-1:0] ghr;

    logic [CTR_BITS-1:0] pht        [PHT_ENTRIES];
    logic                btb_valid  [BTB_ENTRIES];
    logic [TW-1:0]       btb_tag    [BTB_ENTRIES];
    logic [31:0]         btb_target [BTB_ENTRIES];

    function automatic logic [IW-1:0] pht_index(input logic [31:0] pc, input logic [GHR_BITS-1:0] hist);
        logic [IW-1:0] idx;
        idx = pc[IW+1:2];
        if (MODE == 1) idx = idx ^ IW'(hist);
        return idx;
    endfunction

    logic [IW-1:0]       if_pht_idx, upd_pht_idx;
    logic [BW-1:0]       if_btb_idx, upd_btb_idx;
    logic [CTR_BITS-1:0] ctr_cur, ctr_next;
    logic                upd_accept;
    logic [GHR_BITS:0]   ghr_spec_wide, ghr_repair_wide;

    assign if_pht_idx  = pht_index(if_pc, ghr);
    assign upd_pht_idx = pht_index(upd_pc, upd_ghr);
    assign if_btb_idx  = if_pc[BW+1:2];
    assign upd_btb_idx = upd_pc[BW+1:2];
    assign upd_accept  = upd_valid & init_done;

    // Reads are asynchronous; a write in the same cycle is only visible after the edge.
    assign btb_hit     = init_done & btb_valid[if_btb_idx] & (btb_tag[if_btb_idx] == if_pc[31:BW+2]);
    assign pred_taken  = init_done & if_is_branch & pht[if_pht_idx][CTR_BITS-1] & btb_hit;
    assign pred_target = pred_taken ? btb_target[if_btb_idx] : if_pc + 32'd4;
    assign pred_ghr    = ghr;

    // Widen by one bit so the shift also works for a single-bit history.
    assign ghr_spec_wide   = {ghr, pred_taken};
    assign ghr_repair_wide = {upd_ghr, upd_taken};

    always_comb begin
        ctr_cur  = pht[upd_pht_idx];
        ctr_next = ctr_cur;
        if (upd_taken && ctr_cur != CTR_MAX)
            ctr_next = ctr_cur + 1'b1;
        else if (!upd_taken && ctr_cur != '0)
            ctr_next = ctr_cur - 1'b1;
    end

    // NOTE: all clocked state uses non-blocking assignments so every reader sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= ST_INIT;
            sweep_cnt        <= '0;
            init_done        <= 1'b0;
            ghr              <= '0;
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (sweep_cnt == SCW'(SWEEP - 1)) begin
                        state     <= ST_READY;
                        init_done <= 1'b1;
                    end else begin
                        sweep_cnt <= sweep_cnt + 1'b1;
                    end
                end
                ST_READY: ;
                default: state <= ST_INIT;
            endcase

            // Repair wins over a speculative shift issued in the same cycle.
            if (upd_accept && upd_mispredict)
                ghr <= ghr_repair_wide[GHR_BITS-1:0];
            else if (if_is_branch && !stall && init_done)
                ghr <= ghr_spec_wide[GHR_BITS-1:0];

            if (upd_accept) begin
                if (stat_branches != '1)
                    stat_branches <= stat_branches + 1'b1;
                if (upd_mispredict && stat_mispredicts != '1)
                    stat_mispredicts <= stat_mispredicts + 1'b1;
            end
        end
    end

    // NOTE: tables have no reset so they can map to RAM; the INIT sweep clears them instead.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == ST_INIT) begin
                if (sweep_cnt < SCW'(PHT_ENTRIES))
                    pht[sweep_cnt[IW-1:0]] <= CTR_WNT;
                if (sweep_cnt < SCW'(BTB_ENTRIES))
                    btb_valid[sweep_cnt[BW-1:0]] <= 1'b0;
            end else if (upd_valid) begin
                pht[upd_pht_idx] <= ctr_next;
                if (upd_taken) begin
                    btb_valid[upd_btb_idx]  <= 1'b1;
                    btb_tag[upd_btb_idx]    <= upd_pc[31:BW+2];
                    btb_target[upd_btb_idx] <= upd_target;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_pred_unit.sv
// Directed bench for branch_pred_unit in bimodal mode: init sweep, training, hysteresis,
// history shift/stall, repair priority, BTB aliasing.
module tb_branch_pred_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] if_pc = '0;
    logic        if_is_branch = 1'b0;
    logic        stall = 1'b0;
    logic        pred_taken;
    logic        btb_hit;
    logic [31:0] pred_target;
    logic [7:0]  pred_ghr;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic [7:0]  upd_ghr = '0;
    logic        upd_mispredict = 1'b0;
    logic        init_done;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] PC_A = 32'h0040_0010;
    localparam logic [31:0] TG_A = 32'h0040_0040;
    localparam logic [31:0] PC_B = 32'h0040_0020;
    localparam logic [31:0] PC_C = 32'h0040_0030;
    localparam logic [31:0] PC_D = 32'h0040_0110;
    localparam logic [31:0] TG_D = 32'h0040_0200;

    branch_pred_unit #(
        .PHT_ENTRIES(256), .BTB_ENTRIES(64), .GHR_BITS(8), .CTR_BITS(2), .MODE(0)
    ) dut (
        .clk(clk), .reset(reset),
        .if_pc(if_pc), .if_is_branch(if_is_branch), .stall(stall),
        .pred_taken(pred_taken), .btb_hit(btb_hit), .pred_target(pred_target), .pred_ghr(pred_ghr),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_ghr(upd_ghr), .upd_mispredict(upd_mispredict),
        .init_done(init_done), .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_init(output int cycles);
        cycles = 0;
        while (!init_done && cycles < 1000) begin
            tick();
            cycles++;
        end
    endtask

    task automatic apply_update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                                input logic [7:0] hist, input logic mis);
        upd_valid      = 1'b1;
        upd_pc         = pc;
        upd_taken      = taken;
        upd_target     = tgt;
        upd_ghr        = hist;
        upd_mispredict = mis;
        tick();
        upd_valid      = 1'b0;
        upd_mispredict = 1'b0;
    endtask

    task automatic probe(input logic [31:0] pc);
        if_pc        = pc;
        if_is_branch = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        int n;
        do_reset();
        n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL reset_init_done: got %b want 0", init_done); end
        n_checks++; if (pred_ghr !== 8'h00) begin n_fail++; $display("FAIL reset_ghr: got %h want 00", pred_ghr); end
        probe(32'h0040_0000);
        n_checks++; if (pred_target !== 32'h0040_0004) begin n_fail++; $display("FAIL init_target: got %h want 00400004", pred_target); end
        n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL init_taken: got %b want 0", pred_taken); end
        n_checks++; if (btb_hit !== 1'b0) begin n_fail++; $display("FAIL init_btb_hit: got %b want 0", btb_hit); end
        if_is_branch = 1'b0;
        // An update with repair during the sweep must be ignored entirely.
        apply_update(PC_A, 1'b1, TG_A, 8'h55, 1'b1);
        wait_init(n);
        n_checks++; if (n + 1 !== 256) begin n_fail++; $display("FAIL sweep_length: got %0d want 256", n + 1); end
        n_checks++; if (stat_branches !== 32'd0) begin n_fail++; $display("FAIL init_upd_ignored: got %0d want 0", stat_branches); end
        n_checks++; if (stat_mispredicts !== 32'd0) begin n_fail++; $display("FAIL init_mis_ignored: got %0d want 0", stat_mispredicts); end
        n_checks++; if (pred_ghr !== 8'h00) begin n_fail++; $display("FAIL init_repair_ignored: got %h want 00", pred_ghr); end
        probe(PC_A);
        n_checks++; if (btb_hit !== 1'b0) begin n_fail++; $display("FAIL init_btb_untouched: got %b want 0", btb_hit); end
        if_is_branch = 1'b0;
    endtask

    task automatic test_reset_restart;
        int n;
        do_reset();
        repeat (100) tick();
        n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL restart_mid: got %b want 0", init_done); end
        do_reset();
        wait_init(n);
        n_checks++; if (n !== 256) begin n_fail++; $display("FAIL restart_sweep_length: got %0d want 256", n); end
    endtask

    task automatic test_counter_training;
        probe(PC_A);
        n_checks++; if (btb_hit !== 1'b0) begin n_fail++; $display("FAIL train_cold_hit: got %b want 0", btb_hit); end
        n_checks++; if (pred_target !== PC_A + 32'd4) begin n_fail++; $display("FAIL train_cold_target: got %h want %h", pred_target, PC_A + 32'd4); end
        if_is_branch = 1'b0;
        // First update with a same-cycle fetch of the same entry: old (empty) value is seen.
        upd_valid = 1'b1; upd_pc = PC_A; upd_taken = 1'b1; upd_target = TG_A; upd_ghr = 8'h00; upd_mispredict = 1'b0;
        probe(PC_A);
        n_checks++; if (btb_hit !== 1'b0) begin n_fail++; $display("FAIL no_bypass_hit: got %b want 0", btb_hit); end
        if_is_branch = 1'b0;
        tick();
        upd_valid = 1'b0;
        apply_update(PC_A, 1'b1, TG_A, 8'h00, 1'b0);
        probe(PC_A);
        n_checks++; if (btb_hit !== 1'b1) begin n_fail++; $display("FAIL train_hit: got %b want 1", btb_hit); end
        n_checks++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL train_taken: got %b want 1", pred_taken); end
        n_checks++; if (pred_target !== TG_A) begin n_fail++; $display("FAIL train_target: got %h want %h", pred_target, TG_A); end
        if_is_branch = 1'b0;
        n_checks++; if (stat_branches !== 32'd2) begin n_fail++; $display("FAIL train_stat: got %0d want 2", stat_branches); end
    endtask

    task automatic test_saturation;
        repeat (3) apply_update(PC_A, 1'b1, TG_A, 8'h00, 1'b0);
        probe(PC_A);
        n_checks++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL sat_taken: got %b want 1", pred_taken); end
        if_is_branch = 1'b0;
        apply_update(PC_A, 1'b0, 32'h0, 8'h00, 1'b0);
        probe(PC_A);
        n_checks++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL hyst_taken: got %b want 1", pred_taken); end
        n_checks++; if (pred_target !== TG_A) begin n_fail++; $display("FAIL hyst_target: got %h want %h", pred_target, TG_A); end
        if_is_branch = 1'b0;
        apply_update(PC_A, 1'b0, 32'h0, 8'h00, 1'b0);
        probe(PC_A);
        n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL flip_taken: got %b want 0", pred_taken); end
        n_checks++; if (btb_hit !== 1'b1) begin n_fail++; $display("FAIL flip_hit: got %b want 1", btb_hit); end
        n_checks++; if (pred_target !== 32'h0040_0014) begin n_fail++; $display("FAIL flip_target: got %h want 00400014", pred_target); end
        if_is_branch = 1'b0;
        n_checks++; if (stat_branches !== 32'd7) begin n_fail++; $display("FAIL sat_stat: got %0d want 7", stat_branches); end
    endtask

    task automatic test_ghr_stall;
        int n;
        do_reset();
        wait_init(n);
        n_checks++; if (pred_ghr !== 8'h00) begin n_fail++; $display("FAIL ghr_start: got %h want 00", pred_ghr); end
        apply_update(PC_A, 1'b1, TG_A, 8'h00, 1'b0);
        apply_update(PC_A, 1'b1, TG_A, 8'h00, 1'b0);
        stall = 1'b0;
        probe(PC_A);
        n_checks++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL ghr_fetch1: got %b want 1", pred_taken); end
        tick();
        n_checks++; if (pred_ghr !== 8'h01) begin n_fail++; $display("FAIL ghr_after1: got %h want 01", pred_ghr); end
        probe(PC_B);
        n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL ghr_fetch2: got %b want 0", pred_taken); end
        tick();
        n_checks++; if (pred_ghr !== 8'h02) begin n_fail++; $display("FAIL ghr_after2: got %h want 02", pred_ghr); end
        probe(PC_A);
        tick();
        n_checks++; if (pred_ghr !== 8'h05) begin n_fail++; $display("FAIL ghr_after3: got %h want 05", pred_ghr); end
        stall = 1'b1;
        probe(PC_A);
        tick();
        n_checks++; if (pred_ghr !== 8'h05) begin n_fail++; $display("FAIL ghr_stalled: got %h want 05", pred_ghr); end
        stall = 1'b0;
        if_is_branch = 1'b0;
    endtask

    task automatic test_repair;
        probe(PC_A);
        apply_update(PC_C, 1'b0, 32'h0, 8'h03, 1'b1);
        if_is_branch = 1'b0;
        n_checks++; if (pred_ghr !== 8'h06) begin n_fail++; $display("FAIL repair_ghr: got %h want 06", pred_ghr); end
        n_checks++; if (stat_mispredicts !== 32'd1) begin n_fail++; $display("FAIL repair_mis_stat: got %0d want 1", stat_mispredicts); end
        n_checks++; if (stat_branches !== 32'd3) begin n_fail++; $display("FAIL repair_br_stat: got %0d want 3", stat_branches); end
        // Mispredict flag alone, without upd_valid, does nothing.
        upd_mispredict = 1'b1; upd_ghr = 8'hF0; upd_taken = 1'b1;
        tick();
        upd_mispredict = 1'b0;
        n_checks++; if (stat_mispredicts !== 32'd1) begin n_fail++; $display("FAIL lone_mis_stat: got %0d want 1", stat_mispredicts); end
        n_checks++; if (pred_ghr !== 8'h06) begin n_fail++; $display("FAIL lone_mis_ghr: got %h want 06", pred_ghr); end
    endtask

    task automatic test_btb_alias;
        apply_update(PC_A, 1'b1, TG_A, 8'h00, 1'b0);
        apply_update(PC_D, 1'b1, TG_D, 8'h00, 1'b0);
        probe(PC_A);
        n_checks++; if (btb_hit !== 1'b0) begin n_fail++; $display("FAIL alias_evicted_hit: got %b want 0", btb_hit); end
        n_checks++; if (pred_target !== 32'h0040_0014) begin n_fail++; $display("FAIL alias_evicted_target: got %h want 00400014", pred_target); end
        probe(PC_D);
        n_checks++; if (btb_hit !== 1'b1) begin n_fail++; $display("FAIL alias_new_hit: got %b want 1", btb_hit); end
        n_checks++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL alias_new_taken: got %b want 1", pred_taken); end
        n_checks++; if (pred_target !== TG_D) begin n_fail++; $display("FAIL alias_new_target: got %h want %h", pred_target, TG_D); end
        if_is_branch = 1'b0;
    endtask

    initial begin
        test_reset();
        test_reset_restart();
        test_counter_training();
        test_saturation();
        test_ghr_stall();
        test_repair();
        test_btb_alias();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
